// File: rtl/radio_rssi_sampler_pkg.sv
// Shared definitions for the RSSI sampler: sample width, sampler states and
// the averaging accumulator width.
package radio_rssi_sampler_pkg;

    localparam int unsigned RSSI_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Sum of 2^avg_log2 samples of RSSI_WIDTH bits never exceeds this width.
    function automatic int unsigned acc_width(input int unsigned avg_log2);
        return RSSI_WIDTH + avg_log2;
    endfunction

endpackage

// File: rtl/radio_rssi_clkgen.sv
// RSSI ADC clock generator: free-running divider while enabled, registered
// 50% duty output clock, and a capture strobe on the generated falling edge.
module radio_rssi_clkgen #(
    parameter int unsigned C_CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic adc_clk,
    output logic capture
);

    localparam int unsigned HALF = C_CLK_DIV / 2;
    localparam int unsigned CW   = $clog2(C_CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          adc_clk_q, adc_clk_d;

    // Divider advance and clock level; both forced low when disabled.
    always_comb begin
        cnt_d     = '0;
        adc_clk_d = 1'b0;
        if (enable) begin
            cnt_d     = (cnt_q == CW'(C_CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
            adc_clk_d = (cnt_q < CW'(HALF));
        end
    end

    // Divider and clock output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            adc_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            adc_clk_q <= adc_clk_d;
        end
    end

    // The edge that ends cnt == HALF is the one where adc_clk_q falls.
    assign capture = enable && (cnt_q == CW'(HALF));
    assign adc_clk = adc_clk_q;

endmodule

// File: rtl/radio_rssi_sampler.sv
// RSSI sampler: drives the bridge RSSI ADC clock, captures samples on the
// generated falling edge, drops pipeline-fill samples after enable, and
// produces per-sample, block-average and peak-hold values.
module radio_rssi_sampler
    import radio_rssi_sampler_pkg::*;
#(
    parameter int unsigned C_CLK_DIV  = 8,
    parameter int unsigned C_AVG_LOG2 = 4,
    parameter int unsigned C_DISCARD  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_peak,
    output logic                  user_RSSI_ADC_clk,
    input  logic [RSSI_WIDTH-1:0] user_RSSI_ADC_D,
    output logic [RSSI_WIDTH-1:0] rssi_sample,
    output logic                  rssi_sample_valid,
    output logic [RSSI_WIDTH-1:0] rssi_avg,
    output logic                  rssi_avg_valid,
    output logic [RSSI_WIDTH-1:0] rssi_peak
);

    localparam int unsigned AW = acc_width(C_AVG_LOG2);

    state_e state_q, state_d;

    logic                  capture;
    logic                  accept;
    logic                  discarding;
    logic                  starting;

    logic [3:0]            disc_q, disc_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [AW-1:0]         sum;
    logic [C_AVG_LOG2-1:0] blk_q, blk_d;
    logic [RSSI_WIDTH-1:0] sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [RSSI_WIDTH-1:0] avg_q, avg_d;
    logic                  avg_valid_q, avg_valid_d;
    logic [RSSI_WIDTH-1:0] peak_q, peak_d;

    radio_rssi_clkgen #(
        .C_CLK_DIV (C_CLK_DIV)
    ) u_clkgen (
        .clk     (clk),
        .rst     (reset),
        .enable  (enable),
        .adc_clk (user_RSSI_ADC_clk),
        .capture (capture)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enable low always returns to idle on the next edge.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = (C_DISCARD == 0) ? ST_RUN : ST_DISCARD;
                ST_DISCARD: if (capture && disc_q == 4'd1) state_d = ST_RUN;
                ST_RUN:     state_d = ST_RUN;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: qualify the capture strobe by state.
    always_comb begin
        accept     = capture && (state_q == ST_RUN);
        discarding = capture && (state_q == ST_DISCARD);
        starting   = enable  && (state_q == ST_IDLE);
    end

    // Datapath next values: discard count, accumulator, sample/avg/peak.
    always_comb begin
        disc_d         = disc_q;
        acc_d          = acc_q;
        blk_d          = blk_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        avg_d          = avg_q;
        avg_valid_d    = 1'b0;
        peak_d         = peak_q;
        sum            = acc_q + AW'(user_RSSI_ADC_D);

        if (state_q == ST_IDLE) begin
            disc_d = 4'(C_DISCARD);
            acc_d  = '0;
            blk_d  = '0;
        end else if (discarding) begin
            disc_d = disc_q - 4'd1;
        end

        if (accept) begin
            sample_d       = user_RSSI_ADC_D;
            sample_valid_d = 1'b1;
            if (blk_q == '1) begin
                avg_d       = RSSI_WIDTH'(sum >> C_AVG_LOG2);
                avg_valid_d = 1'b1;
                acc_d       = '0;
                blk_d       = '0;
            end else begin
                acc_d = sum;
                blk_d = blk_q + 1'b1;
            end
        end

        // A clear coinciding with an accepted sample leaves just that sample.
        if (starting) begin
            peak_d = '0;
        end else if (clear_peak) begin
            peak_d = accept ? user_RSSI_ADC_D : '0;
        end else if (accept && (user_RSSI_ADC_D > peak_q)) begin
            peak_d = user_RSSI_ADC_D;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disc_q         <= 4'(C_DISCARD);
            acc_q          <= '0;
            blk_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            avg_q          <= '0;
            avg_valid_q    <= 1'b0;
            peak_q         <= '0;
        end else begin
            disc_q         <= disc_d;
            acc_q          <= acc_d;
            blk_q          <= blk_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            avg_q          <= avg_d;
            avg_valid_q    <= avg_valid_d;
            peak_q         <= peak_d;
        end
    end

    assign rssi_sample       = sample_q;
    assign rssi_sample_valid = sample_valid_q;
    assign rssi_avg          = avg_q;
    assign rssi_avg_valid    = avg_valid_q;
    assign rssi_peak         = peak_q;

endmodule

// File: tb/tb_radio_rssi_sampler.sv
// Directed bench for radio_rssi_sampler with default parameters
// (C_CLK_DIV=8, C_AVG_LOG2=4, C_DISCARD=3) and a simple bridge model.
module tb_radio_rssi_sampler;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       clear_peak;
    logic       user_RSSI_ADC_clk;
    logic [9:0] user_RSSI_ADC_D;
    logic [9:0] rssi_sample;
    logic       rssi_sample_valid;
    logic [9:0] rssi_avg;
    logic       rssi_avg_valid;
    logic [9:0] rssi_peak;

    logic [9:0] bridge_in;
    logic       adc_clk_prev;

    int n_checks;
    int n_fail;

    radio_rssi_sampler #(
        .C_CLK_DIV  (8),
        .C_AVG_LOG2 (4),
        .C_DISCARD  (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .clear_peak        (clear_peak),
        .user_RSSI_ADC_clk (user_RSSI_ADC_clk),
        .user_RSSI_ADC_D   (user_RSSI_ADC_D),
        .rssi_sample       (rssi_sample),
        .rssi_sample_valid (rssi_sample_valid),
        .rssi_avg          (rssi_avg),
        .rssi_avg_valid    (rssi_avg_valid),
        .rssi_peak         (rssi_peak)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bridge: latches bridge_in one clk after it sees the RSSI clock rise.
    initial begin
        adc_clk_prev    = 1'b0;
        user_RSSI_ADC_D = '0;
    end
    always @(posedge clk) begin
        adc_clk_prev <= user_RSSI_ADC_clk;
        if (user_RSSI_ADC_clk && !adc_clk_prev) user_RSSI_ADC_D <= bridge_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next sample_valid; returns negedges elapsed.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (rssi_sample_valid !== 1'b1 && cycles < 100);
    endtask

    int         cyc;
    int         pulses;
    logic [7:0] clk_pat;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        clear_peak = 1'b0;
        bridge_in  = 10'h155;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_clk",    32'(user_RSSI_ADC_clk), 32'd0);
        check("rst_sample", 32'(rssi_sample),       32'd0);
        check("rst_svalid", 32'(rssi_sample_valid), 32'd0);
        check("rst_avg",    32'(rssi_avg),          32'd0);
        check("rst_avalid", 32'(rssi_avg_valid),    32'd0);
        check("rst_peak",   32'(rssi_peak),         32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Clock generation and discard with 10'h155
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clk_pat[7 - i] = user_RSSI_ADC_clk;
            check("discard_no_valid", 32'(rssi_sample_valid), 32'd0);
        end
        check("clk_pattern", 32'(clk_pat), 32'h0F0);
        wait_valid(cyc);
        check("first_valid_cycles", 32'(cyc + 8), 32'd29);
        check("first_sample", 32'(rssi_sample), 32'h155);
        check("first_peak",   32'(rssi_peak),   32'h155);
        @(negedge clk);
        check("valid_one_cycle", 32'(rssi_sample_valid), 32'd0);

        // Averaging: restart, then samples 0..15 and 16 x 3FF
        enable = 1'b0;
        repeat (3) @(negedge clk);
        bridge_in = 10'd0;
        enable = 1'b1;
        wait_valid(cyc);
        check("avg_start_cycles", 32'(cyc), 32'd29);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                wait_valid(cyc);
                check("avg_ramp_period", 32'(cyc), 32'd8);
            end
            check("avg_ramp_sample", 32'(rssi_sample), 32'(k));
            check("avg_ramp_avalid", 32'(rssi_avg_valid), 32'(k == 15));
            bridge_in = (k == 15) ? 10'h3FF : 10'(k + 1);
        end
        check("avg_ramp_value", 32'(rssi_avg), 32'd7);
        for (int k = 0; k < 16; k++) begin
            wait_valid(cyc);
            check("avg_max_period", 32'(cyc), 32'd8);
            check("avg_max_avalid", 32'(rssi_avg_valid), 32'(k == 15));
        end
        check("avg_max_value", 32'(rssi_avg), 32'h3FF);
        check("peak_max",      32'(rssi_peak), 32'h3FF);

        // Peak hold
        clear_peak = 1'b1;
        @(negedge clk);
        clear_peak = 1'b0;
        check("peak_clear_alone1", 32'(rssi_peak), 32'd0);
        bridge_in = 10'd100;
        wait_valid(cyc);
        bridge_in = 10'd900;
        wait_valid(cyc);
        bridge_in = 10'd200;
        wait_valid(cyc);
        check("peak_900", 32'(rssi_peak), 32'd900);
        bridge_in = 10'd50;
        repeat (7) @(negedge clk);
        clear_peak = 1'b1;
        @(negedge clk);
        clear_peak = 1'b0;
        check("peak_clr_sample_v", 32'(rssi_sample_valid), 32'd1);
        check("peak_clr_sample",   32'(rssi_peak),         32'd50);
        clear_peak = 1'b1;
        @(negedge clk);
        clear_peak = 1'b0;
        check("peak_clear_alone2", 32'(rssi_peak), 32'd0);

        // Enable drop after 9 accepted samples in the block
        bridge_in = 10'd7;
        for (int k = 0; k < 5; k++) begin
            wait_valid(cyc);
            check("partial_avalid", 32'(rssi_avg_valid), 32'd0);
        end
        repeat (4) @(negedge clk);
        check("drop_clk_high", 32'(user_RSSI_ADC_clk), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("drop_clk_low", 32'(user_RSSI_ADC_clk), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (rssi_sample_valid || rssi_avg_valid || user_RSSI_ADC_clk) pulses++;
            @(negedge clk);
        end
        check("idle_quiet", 32'(pulses), 32'd0);
        check("idle_avg_hold", 32'(rssi_avg), 32'h3FF);

        // Re-enable: fresh block of 16 x 40
        bridge_in = 10'd40;
        enable = 1'b1;
        wait_valid(cyc);
        check("reen_cycles", 32'(cyc), 32'd29);
        check("reen_peak", 32'(rssi_peak), 32'd40);
        check("reen_avalid0", 32'(rssi_avg_valid), 32'd0);
        for (int k = 1; k < 16; k++) begin
            wait_valid(cyc);
            check("reen_avalid", 32'(rssi_avg_valid), 32'(k == 15));
        end
        check("reen_avg", 32'(rssi_avg), 32'd40);

        // Reset mid-run with enable held high
        repeat ($urandom_range(3, 20)) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_clk",    32'(user_RSSI_ADC_clk), 32'd0);
        check("mid_rst_sample", 32'(rssi_sample),       32'd0);
        check("mid_rst_avg",    32'(rssi_avg),          32'd0);
        check("mid_rst_peak",   32'(rssi_peak),         32'd0);
        check("mid_rst_valids", 32'({rssi_sample_valid, rssi_avg_valid}), 32'd0);
        bridge_in = 10'h2AA;
        @(negedge clk);
        reset = 1'b0;
        wait_valid(cyc);
        check("mid_rst_cycles", 32'(cyc), 32'd29);
        check("mid_rst_first",  32'(rssi_sample), 32'h2AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
